// File: rtl/hg_pipe_s00_axi_regs.sv
// AXI4-Lite slave register file for the HG_PIPE S00_AXI control port.
// Independent write/read FSMs; registers are exported with a per-register commit pulse.
module hg_pipe_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  wstate_t         wstate_q;
  rstate_t         rstate_q;
  logic [DW-1:0]   regs_q [NUM_REGS];

  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [SW-1:0]   w_strb_q;
  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic [NUM_REGS-1:0] pulse_q;

  logic            arready_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;

  logic            aw_hs;
  logic            w_hs;
  logic            ar_hs;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            wr_oor;
  logic            rd_oor;

  assign aw_hs  = s00_axi_awvalid && awready_q;
  assign w_hs   = s00_axi_wvalid  && wready_q;
  assign ar_hs  = s00_axi_arvalid && arready_q;

  // Any address bit above the register index field marks the access out of range.
  assign wr_idx = aw_addr_q[2 +: IW];
  assign rd_idx = s00_axi_araddr[2 +: IW];
  assign wr_oor = (aw_addr_q >> (2 + IW)) != '0;
  assign rd_oor = (s00_axi_araddr >> (2 + IW)) != '0;

  // Write channel: collect AW and W in either order, commit, then hold B.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wstate_q  <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pulse_q <= '0;
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          if (aw_hs) begin
            aw_addr_q <= s00_axi_awaddr;
          end
          if (w_hs) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
          end
          if (aw_hs && w_hs) begin
            wstate_q  <= W_COMMIT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else if (aw_hs) begin
            wstate_q  <= W_HAVE_AW;
            awready_q <= 1'b0;
          end else if (w_hs) begin
            wstate_q <= W_HAVE_W;
            wready_q <= 1'b0;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
            wstate_q <= W_COMMIT;
            wready_q <= 1'b0;
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            aw_addr_q <= s00_axi_awaddr;
            wstate_q  <= W_COMMIT;
            awready_q <= 1'b0;
          end
        end
        W_COMMIT: begin
          bvalid_q <= 1'b1;
          wstate_q <= W_RESP;
          if (wr_oor) begin
            bresp_q <= RESP_SLVERR;
          end else begin
            bresp_q         <= RESP_OKAY;
            pulse_q[wr_idx] <= 1'b1;
            for (int b = 0; b < SW; b++) begin
              if (w_strb_q[b]) begin
                regs_q[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
              end
            end
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            bvalid_q  <= 1'b0;
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          wstate_q <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel: the register value is captured on the AR handshake edge,
  // so a read landing on a commit edge returns the pre-write contents.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rstate_q  <= R_RESP;
            if (rd_oor) begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end else begin
              rdata_q <= regs_q[rd_idx];
              rresp_q <= RESP_OKAY;
            end
          end
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: begin
          rstate_q <= R_IDLE;
        end
      endcase
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign reg_wr_pulse    = pulse_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
    assign reg_q[DW*gi +: DW] = regs_q[gi];
  end

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_q[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_hg_pipe_s00_axi_regs.sv
// Directed bench for hg_pipe_s00_axi_regs with a response scoreboard and a register model.
module tb_hg_pipe_s00_axi_regs;

  localparam int AW = 6;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [31:0]    wdata = '0;
  logic [3:0]     wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [32*NR-1:0] reg_q;
  logic [NR-1:0]  reg_wr_pulse;

  always #5 clk = ~clk;

  hg_pipe_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr),
    .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),
    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NR];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  int pulse_cnt [NR];

  initial begin
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (reg_wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
    end
  end

  function automatic logic [32*NR-1:0] model_q();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_oor(input logic [AW-1:0] a);
    return (a >> 4) != 0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!addr_oor(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Waits for B with bready high; the first cycle bvalid is seen is the commit cycle.
  task automatic wait_b(input string tag, input logic [NR-1:0] exp_pulse);
    int n;
    logic [1:0] e;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      chk({tag, "_bresp"}, bresp, e);
    end
    chk({tag, "_pulse"}, reg_wr_pulse, exp_pulse);
    chk({tag, "_reg_q"}, reg_q, model_q());
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_bdone"}, bvalid, 1'b0);
    $display("write %s addr=0x%0h bresp=%0d reg_q=0x%0h", tag, awaddr, bresp, reg_q);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    bit aw_done, w_done, awf, wf;
    logic [NR-1:0] exp_pulse;
    exp_pulse = '0;
    if (!addr_oor(a)) exp_pulse[a[3:2]] = 1'b1;
    exp_b_q.push_back(addr_oor(a) ? 2'b10 : 2'b00);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      awf = awvalid && awready;
      wf  = wvalid && wready;
      @(negedge clk);
      n++;
      if (awf) begin awvalid = 1'b0; aw_done = 1; end
      if (wf)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    chk({tag, "_hs"}, {aw_done, w_done}, 2'b11);
    model_write(a, d, s);
    wait_b(tag, exp_pulse);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a);
    int n;
    logic [33:0] e;
    exp_r_q.push_back(addr_oor(a) ? {2'b10, 32'h0} : {2'b00, model[a[3:2]]});
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arready"}, arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    if (exp_r_q.size() > 0) begin
      e = exp_r_q.pop_front();
      chk({tag, "_rdata"}, rdata, e[31:0]);
      chk({tag, "_rresp"}, rresp, e[33:32]);
    end
    $display("read %s addr=0x%0h rdata=0x%0h rresp=%0d", tag, a, rdata, rresp);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p1_before;
    logic [1:0] held_resp;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_resp", {bresp, rresp}, 4'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_q", reg_q, '0);
    chk("rst_pulse", reg_wr_pulse, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word writes then readback
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      a = AW'(4 * i);
      do_write("wr_full", a, 32'(i + 1), 4'hF);
    end
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      a = AW'(4 * i);
      do_read("rd_full", a);
    end

    // Partial strobes over reg1 = 2
    p1_before = pulse_cnt[1];
    do_write("wr_strb", 6'h04, 32'hAABBCCDD, 4'b0101);
    repeat (2) @(negedge clk);
    chk("strb_pulse_count", pulse_cnt[1] - p1_before, 1);
    chk("strb_model", model[1], 32'h00BB00DD);
    do_read("rd_strb", 6'h04);

    // W presented three cycles before AW
    @(negedge clk);
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 1'b0);
    chk("wfirst_awready", awready, 1'b1);
    repeat (2) @(negedge clk);
    awaddr = 6'h08; awvalid = 1'b1;
    exp_b_q.push_back(2'b00);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_b_early", bvalid, 1'b0);
    chk("wfirst_reg_early", reg_q, model_q());
    bready = 1'b1;
    model_write(6'h08, 32'h55, 4'hF);
    @(negedge clk);
    chk("wfirst_b_latency", bvalid, 1'b1);
    wait_b("wr_wfirst", 4'b0100);

    // bready held low: B stays stable and a new AW is refused
    exp_b_q.push_back(2'b00);
    @(negedge clk);
    awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(6'h0C, 32'h77, 4'hF);
    @(negedge clk);
    chk("bhold_bvalid_rise", bvalid, 1'b1);
    held_resp = exp_b_q.pop_front();
    awaddr = 6'h00; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", bvalid, 1'b1);
      chk("bhold_bresp", bresp, held_resp);
      chk("bhold_awready", awready, 1'b0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    awvalid = 1'b0;
    chk("bhold_bdone", bvalid, 1'b0);
    chk("bhold_awready_back", awready, 1'b1);
    chk("bhold_reg_q", reg_q, model_q());
    $display("write bhold addr=0xc bresp=%0d reg_q=0x%0h", held_resp, reg_q);

    // Out-of-range access
    do_write("wr_oor", 6'h10, 32'hDEAD_BEEF, 4'hF);
    do_read("rd_oor", 6'h10);
    do_read("rd_after_oor", 6'h0C);

    // Reset while holding AW
    @(negedge clk);
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid_have_aw_awready", awready, 1'b0);
    chk("mid_have_aw_wready", wready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", awready, 1'b0);
    chk("mid_rst_wready", wready, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_reg_q", reg_q, '0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_bvalid", bvalid, 1'b0);
    do_write("wr_post_rst", 6'h04, 32'h0000_1234, 4'hF);
    do_read("rd_post_rst", 6'h04);
    do_read("rd_post_rst0", 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
